// File: rtl/ctrl_cmd_sequencer.sv
// ctrl_cmd_sequencer: whitelist-checked command gate for the 4-bit control FSM.
// Legal commands become single-cycle one-hot control pulses followed by a cooldown;
// illegal commands are rejected, counted, and escalate to a sticky lockout.
module ctrl_cmd_sequencer #(
    parameter int unsigned COOLDOWN = 3,
    parameter int unsigned MAX_ERR  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_code,
    output logic       cmd_ready,
    input  logic       err_clr,
    output logic [3:0] control,
    output logic [3:0] shadow_state,
    output logic       err_illegal,
    output logic [3:0] err_count,
    output logic       locked
);

    typedef enum logic [1:0] {StIdle, StIssue, StCool, StLock} state_e;

    localparam logic [3:0] CoolInit = 4'(COOLDOWN);
    localparam logic [3:0] MaxErr   = 4'(MAX_ERR);

    state_e     state_q, state_d;
    logic [3:0] cool_q, cool_d;
    logic [3:0] control_d, shadow_d, err_count_d;
    logic       err_illegal_d, locked_d;

    logic       accept;
    logic       legal;
    logic [3:0] onehot;
    logic [3:0] err_base, err_inc;

    // Downstream state reached after the pulse currently on control.
    function automatic logic [3:0] shadow_after(input logic [3:0] ctl, input logic [3:0] cur);
        logic [3:0] nxt;
        nxt = cur;
        case (ctl)
            4'b0001: nxt = 4'hA;
            4'b0010: nxt = 4'h5;
            4'b0100: nxt = 4'hF;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;

    // Command decode and whitelist lookup against the tracked downstream state.
    always_comb begin
        onehot = 4'b0000;
        legal  = 1'b0;
        case (cmd_code)
            2'd1:    onehot = 4'b0001;
            2'd2:    onehot = 4'b0010;
            2'd3:    onehot = 4'b0100;
            default: onehot = 4'b0000;
        endcase
        case (shadow_state)
            4'h0:    legal = (cmd_code == 2'd1);
            4'hA:    legal = (cmd_code == 2'd2);
            4'h5:    legal = (cmd_code == 2'd1) || (cmd_code == 2'd3);
            4'hF:    legal = (cmd_code == 2'd1);
            default: legal = 1'b0;
        endcase
    end

    // Error count increment; a same-edge clear is applied before the increment.
    always_comb begin
        err_base = err_clr ? 4'd0 : err_count;
        err_inc  = (err_base == 4'hF) ? 4'hF : err_base + 4'd1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        cool_d        = cool_q;
        control_d     = 4'b0000;
        shadow_d      = shadow_state;
        err_count_d   = err_count;
        err_illegal_d = 1'b0;
        locked_d      = locked;

        if (state_q != StLock && err_clr) begin
            err_count_d = 4'd0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept && cmd_code != 2'd0) begin
                    if (legal) begin
                        state_d   = StIssue;
                        control_d = onehot;
                    end else begin
                        err_illegal_d = 1'b1;
                        err_count_d   = err_inc;
                        if (err_inc >= MaxErr) begin
                            state_d  = StLock;
                            locked_d = 1'b1;
                        end
                    end
                end
            end
            StIssue: begin
                shadow_d = shadow_after(control, shadow_state);
                cool_d   = CoolInit;
                state_d  = (CoolInit == 4'd0) ? StIdle : StCool;
            end
            StCool: begin
                cool_d = cool_q - 4'd1;
                if (cool_q <= 4'd1) begin
                    state_d = StIdle;
                end
            end
            StLock: begin
                locked_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cool_q       <= 4'd0;
            control      <= 4'b0000;
            shadow_state <= 4'h0;
            err_count    <= 4'd0;
            err_illegal  <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cool_q       <= cool_d;
            control      <= control_d;
            shadow_state <= shadow_d;
            err_count    <= err_count_d;
            err_illegal  <= err_illegal_d;
            locked       <= locked_d;
        end
    end

endmodule

// File: tb/tb_ctrl_cmd_sequencer.sv
// Testbench for ctrl_cmd_sequencer: directed scenarios plus randomized traffic against
// a cycle-level behavioural model. Two instances: index 0 (COOLDOWN=3, MAX_ERR=3) and
// index 1 (COOLDOWN=0, MAX_ERR=1) share the same stimulus.
module tb_ctrl_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_code = 2'd0;
    logic       err_clr = 1'b0;

    logic       cmd_ready[2];
    logic [3:0] control[2];
    logic [3:0] shadow_state[2];
    logic       err_illegal[2];
    logic [3:0] err_count[2];
    logic       locked[2];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ctrl_cmd_sequencer #(.COOLDOWN(3), .MAX_ERR(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(cmd_ready[0]), .err_clr(err_clr), .control(control[0]),
        .shadow_state(shadow_state[0]), .err_illegal(err_illegal[0]),
        .err_count(err_count[0]), .locked(locked[0])
    );

    ctrl_cmd_sequencer #(.COOLDOWN(0), .MAX_ERR(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(cmd_ready[1]), .err_clr(err_clr), .control(control[1]),
        .shadow_state(shadow_state[1]), .err_illegal(err_illegal[1]),
        .err_count(err_count[1]), .locked(locked[1])
    );

    // ---------------- behavioural reference model ----------------
    int unsigned cd_p[2] = '{3, 0};
    int unsigned me_p[2] = '{3, 1};

    bit [3:0] m_ctl[2];
    bit [3:0] m_shadow[2];
    int       m_cnt[2];
    int       m_busy[2];   // edges remaining before the block can accept again
    int       m_code[2];   // last issued command
    bit       m_err[2];
    bit       m_locked[2];

    function automatic bit allowed(input bit [3:0] sh, input int code);
        case (sh)
            4'h0:    return code == 1;
            4'hA:    return code == 2;
            4'h5:    return code == 1 || code == 3;
            4'hF:    return code == 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [3:0] target_of(input int code);
        case (code)
            1:       return 4'hA;
            2:       return 4'h5;
            default: return 4'hF;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_ctl[k] = 4'h0; m_shadow[k] = 4'h0; m_cnt[k] = 0; m_busy[k] = 0;
                m_code[k] = 0; m_err[k] = 1'b0; m_locked[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                automatic bit rdy = !m_locked[k] && m_busy[k] == 0;
                automatic bit was_issue = (m_ctl[k] != 4'h0);
                m_ctl[k] = 4'h0;
                m_err[k] = 1'b0;
                if (was_issue) m_shadow[k] = target_of(m_code[k]);
                if (!m_locked[k] && err_clr) m_cnt[k] = 0;
                if (rdy && cmd_valid && cmd_code != 2'd0) begin
                    if (allowed(m_shadow[k], int'(cmd_code))) begin
                        m_ctl[k]  = 4'(1 << (int'(cmd_code) - 1));
                        m_code[k] = int'(cmd_code);
                        m_busy[k] = 1 + int'(cd_p[k]);
                    end else begin
                        m_err[k] = 1'b1;
                        m_cnt[k] = (m_cnt[k] + 1 > 15) ? 15 : m_cnt[k] + 1;
                        if (m_cnt[k] >= int'(me_p[k])) m_locked[k] = 1'b1;
                    end
                end else if (m_busy[k] > 0) begin
                    m_busy[k] = m_busy[k] - 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        cmd_code  = 2'd0;
        rst_n     = 1'b0;
        #2;
        rst_n     = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (control[0] !== 4'h0) $display("FAIL reset_control: got %h expected 0", control[0]); else n_pass++;
        n_checks++; if (shadow_state[0] !== 4'h0) $display("FAIL reset_shadow: got %h expected 0", shadow_state[0]); else n_pass++;
        n_checks++; if (err_illegal[0] !== 1'b0) $display("FAIL reset_err_illegal: got %b expected 0", err_illegal[0]); else n_pass++;
        n_checks++; if (err_count[0] !== 4'h0) $display("FAIL reset_err_count: got %h expected 0", err_count[0]); else n_pass++;
        n_checks++; if (locked[0] !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked[0]); else n_pass++;
        n_checks++; if (cmd_ready[0] !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready[0]); else n_pass++;
    endtask

    task automatic test_legal_sequence();
        logic [1:0] seq[4]     = '{2'd1, 2'd2, 2'd3, 2'd1};
        logic [3:0] exp_ctl[4] = '{4'h1, 4'h2, 4'h4, 4'h1};
        logic [3:0] exp_sh[4]  = '{4'hA, 4'h5, 4'hF, 4'hA};
        int last = 0;
        int bound;
        do_reset();
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_code = seq[i];
            bound = 0;
            while (!cmd_ready[0] && bound < 20) begin
                @(negedge clk);
                bound++;
            end
            n_checks++;
            if (bound >= 20) $display("FAIL legal_ready_timeout: cmd %0d got not-ready expected ready", i);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (control[0] !== exp_ctl[i]) $display("FAIL legal_pulse cmd %0d: got %h expected %h", i, control[0], exp_ctl[i]);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (cyc - last !== 5) $display("FAIL legal_spacing cmd %0d: got %0d expected 5", i, cyc - last);
                else n_pass++;
            end
            last = cyc;
            @(negedge clk);
            n_checks++;
            if (control[0] !== 4'h0) $display("FAIL legal_pulse_end cmd %0d: got %h expected 0", i, control[0]);
            else n_pass++;
            n_checks++;
            if (shadow_state[0] !== exp_sh[i]) $display("FAIL legal_shadow cmd %0d: got %h expected %h", i, shadow_state[0], exp_sh[i]);
            else n_pass++;
            n_checks++;
            if (err_count[0] !== 4'h0) $display("FAIL legal_err_count cmd %0d: got %h expected 0", i, err_count[0]);
            else n_pass++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        cmd_valid = 1'b1;
        cmd_code  = 2'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (err_illegal[0] !== 1'b1) $display("FAIL illegal_pulse: got %b expected 1", err_illegal[0]); else n_pass++;
        n_checks++; if (control[0] !== 4'h0) $display("FAIL illegal_control: got %h expected 0", control[0]); else n_pass++;
        n_checks++; if (err_count[0] !== 4'h1) $display("FAIL illegal_count: got %h expected 1", err_count[0]); else n_pass++;
        n_checks++; if (shadow_state[0] !== 4'h0) $display("FAIL illegal_shadow: got %h expected 0", shadow_state[0]); else n_pass++;
        n_checks++; if (cmd_ready[0] !== 1'b1) $display("FAIL illegal_ready: got %b expected 1", cmd_ready[0]); else n_pass++;
        @(negedge clk);
        n_checks++; if (err_illegal[0] !== 1'b0) $display("FAIL illegal_pulse_end: got %b expected 0", err_illegal[0]); else n_pass++;
    endtask

    task automatic test_lockout();
        bit saw_pulse = 1'b0;
        do_reset();
        cmd_valid = 1'b1;
        cmd_code  = 2'd3;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (err_count[0] !== 4'd3) $display("FAIL lock_count: got %h expected 3", err_count[0]); else n_pass++;
        n_checks++; if (locked[0] !== 1'b1) $display("FAIL lock_flag: got %b expected 1", locked[0]); else n_pass++;
        n_checks++; if (cmd_ready[0] !== 1'b0) $display("FAIL lock_ready: got %b expected 0", cmd_ready[0]); else n_pass++;
        cmd_valid = 1'b1;
        cmd_code  = 2'd1;
        err_clr   = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (control[0] !== 4'h0) saw_pulse = 1'b1;
        end
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        n_checks++; if (saw_pulse) $display("FAIL lock_no_pulse: got pulse expected none"); else n_pass++;
        n_checks++; if (err_count[0] !== 4'd3) $display("FAIL lock_clr_ignored: got %h expected 3", err_count[0]); else n_pass++;
        do_reset();
        n_checks++; if (locked[0] !== 1'b0) $display("FAIL lock_reset_flag: got %b expected 0", locked[0]); else n_pass++;
        n_checks++; if (err_count[0] !== 4'd0) $display("FAIL lock_reset_count: got %h expected 0", err_count[0]); else n_pass++;
        n_checks++; if (cmd_ready[0] !== 1'b1) $display("FAIL lock_reset_ready: got %b expected 1", cmd_ready[0]); else n_pass++;
    endtask

    task automatic test_err_clr();
        int exp_cnt[5] = '{1, 2, 0, 1, 2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i != 2);
            err_clr   = (i == 2);
            cmd_code  = 2'd3;
            @(negedge clk);
            n_checks++;
            if (err_count[0] !== 4'(exp_cnt[i])) $display("FAIL clr_count step %0d: got %h expected %0d", i, err_count[0], exp_cnt[i]);
            else n_pass++;
            n_checks++;
            if (locked[0] !== 1'b0) $display("FAIL clr_locked step %0d: got %b expected 0", i, locked[0]);
            else n_pass++;
        end
        // clear and illegal on the same edge: clear first, then count the new error
        cmd_valid = 1'b1;
        err_clr   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        n_checks++; if (err_count[0] !== 4'd1) $display("FAIL clr_same_edge_count: got %h expected 1", err_count[0]); else n_pass++;
        n_checks++; if (locked[0] !== 1'b0) $display("FAIL clr_same_edge_locked: got %b expected 0", locked[0]); else n_pass++;
        n_checks++; if (err_illegal[0] !== 1'b1) $display("FAIL clr_same_edge_pulse: got %b expected 1", err_illegal[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmd_valid = 1'b1;
        cmd_code  = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (control[0] !== 4'h1) $display("FAIL mid_issue_pulse: got %h expected 1", control[0]); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (control[0] !== 4'h0) $display("FAIL mid_issue_control: got %h expected 0", control[0]); else n_pass++;
        n_checks++; if (shadow_state[0] !== 4'h0) $display("FAIL mid_issue_shadow: got %h expected 0", shadow_state[0]); else n_pass++;
        #1 rst_n = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_code  = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_ready[0] !== 1'b0) $display("FAIL mid_cool_busy: got %b expected 0", cmd_ready[0]); else n_pass++;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        n_checks++; if (cmd_ready[0] !== 1'b1) $display("FAIL mid_cool_ready: got %b expected 1", cmd_ready[0]); else n_pass++;
        n_checks++; if (shadow_state[0] !== 4'h0) $display("FAIL mid_cool_shadow: got %h expected 0", shadow_state[0]); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_zero_cooldown();
        // A then B back-to-back on the COOLDOWN=0 instance
        do_reset();
        cmd_valid = 1'b1;
        cmd_code  = 2'd1;
        @(negedge clk);
        n_checks++; if (control[1] !== 4'h1) $display("FAIL zc_pulse_a: got %h expected 1", control[1]); else n_pass++;
        cmd_code = 2'd2;
        @(negedge clk);
        n_checks++; if (control[1] !== 4'h0) $display("FAIL zc_gap_control: got %h expected 0", control[1]); else n_pass++;
        n_checks++; if (cmd_ready[1] !== 1'b1) $display("FAIL zc_gap_ready: got %b expected 1", cmd_ready[1]); else n_pass++;
        n_checks++; if (shadow_state[1] !== 4'hA) $display("FAIL zc_gap_shadow: got %h expected a", shadow_state[1]); else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (control[1] !== 4'h2) $display("FAIL zc_pulse_b: got %h expected 2", control[1]); else n_pass++;
        // A, NOP, B: NOP is accepted silently
        do_reset();
        cmd_valid = 1'b1;
        cmd_code  = 2'd1;
        @(negedge clk);
        cmd_code = 2'd0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (control[1] !== 4'h0) $display("FAIL zc_nop_control: got %h expected 0", control[1]); else n_pass++;
        n_checks++; if (err_illegal[1] !== 1'b0) $display("FAIL zc_nop_err: got %b expected 0", err_illegal[1]); else n_pass++;
        n_checks++; if (err_count[1] !== 4'h0) $display("FAIL zc_nop_count: got %h expected 0", err_count[1]); else n_pass++;
        n_checks++; if (cmd_ready[1] !== 1'b1) $display("FAIL zc_nop_ready: got %b expected 1", cmd_ready[1]); else n_pass++;
        cmd_code = 2'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (control[1] !== 4'h2) $display("FAIL zc_nop_pulse_b: got %h expected 2", control[1]); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                automatic bit exp_rdy = !m_locked[k] && m_busy[k] == 0;
                n_checks++;
                if (control[k] !== m_ctl[k]) $display("FAIL rand_control i%0d n%0d: got %h expected %h", k, n, control[k], m_ctl[k]);
                else n_pass++;
                n_checks++;
                if (shadow_state[k] !== m_shadow[k]) $display("FAIL rand_shadow i%0d n%0d: got %h expected %h", k, n, shadow_state[k], m_shadow[k]);
                else n_pass++;
                n_checks++;
                if (err_illegal[k] !== m_err[k]) $display("FAIL rand_err_illegal i%0d n%0d: got %b expected %b", k, n, err_illegal[k], m_err[k]);
                else n_pass++;
                n_checks++;
                if (err_count[k] !== 4'(m_cnt[k])) $display("FAIL rand_err_count i%0d n%0d: got %h expected %0d", k, n, err_count[k], m_cnt[k]);
                else n_pass++;
                n_checks++;
                if (locked[k] !== m_locked[k]) $display("FAIL rand_locked i%0d n%0d: got %b expected %b", k, n, locked[k], m_locked[k]);
                else n_pass++;
                n_checks++;
                if (cmd_ready[k] !== exp_rdy) $display("FAIL rand_ready i%0d n%0d: got %b expected %b", k, n, cmd_ready[k], exp_rdy);
                else n_pass++;
            end
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_code  = 2'($urandom_range(0, 3));
            err_clr   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_legal_sequence();
        test_illegal();
        test_lockout();
        test_err_clr();
        test_reset_mid();
        test_zero_cooldown();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
